// File: rtl/alu_exec_pipe.sv
// Two-stage ALU execute pipe: operand register then result register, with
// valid/ready handshakes on both sides and a completed-operation counter.
module alu_exec_pipe #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     src_a_i,
    input  logic [WIDTH-1:0]     src_b_i,
    input  logic [2:0]           alu_control_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [WIDTH-1:0]     result_o,
    output logic                 zero_o,
    output logic                 overflow_o,
    output logic                 illegal_o,
    output logic [CNT_WIDTH-1:0] op_count_o
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b101;

    logic                 s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [2:0]           ctl_q, ctl_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic                 zero_q, zero_d, ovf_q, ovf_d, ill_q, ill_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                 s1_ready, s2_ready, in_fire, adv, out_fire;
    logic [WIDTH-1:0]     sum, diff, alu_res;
    logic                 alu_ovf, alu_ill, lt;

    // ALU datapath on stage-1 contents
    always_comb begin
        sum     = a_q + b_q;
        diff    = a_q - b_q;
        lt      = $signed(a_q) < $signed(b_q);
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (ctl_q)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, lt};
            default: alu_ill = 1'b1;
        endcase
    end

    // Ready chain and next-state for both stages and the counter
    always_comb begin
        s2_ready   = !s2_valid_q || out_ready_i;
        s1_ready   = !s1_valid_q || s2_ready;
        in_fire    = in_valid_i && s1_ready;
        adv        = s1_valid_q && s2_ready;
        out_fire   = s2_valid_q && out_ready_i;

        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        ctl_d      = ctl_q;
        s2_valid_d = s2_valid_q;
        res_d      = res_q;
        zero_d     = zero_q;
        ovf_d      = ovf_q;
        ill_d      = ill_q;
        cnt_d      = cnt_q;

        if (in_fire) begin
            s1_valid_d = 1'b1;
            a_d        = src_a_i;
            b_d        = src_b_i;
            ctl_d      = alu_control_i;
        end else if (adv) begin
            s1_valid_d = 1'b0;
        end

        if (adv) begin
            s2_valid_d = 1'b1;
            res_d      = alu_res;
            zero_d     = (alu_res == '0);
            ovf_d      = alu_ovf;
            ill_d      = alu_ill;
        end else if (out_fire) begin
            s2_valid_d = 1'b0;
        end

        if (out_fire) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            ctl_q      <= '0;
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            ill_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            ctl_q      <= ctl_d;
            s2_valid_q <= s2_valid_d;
            res_q      <= res_d;
            zero_q     <= zero_d;
            ovf_q      <= ovf_d;
            ill_q      <= ill_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready_o  = s1_ready;
    assign out_valid_o = s2_valid_q;
    assign result_o    = res_q;
    assign zero_o      = zero_q;
    assign overflow_o  = ovf_q;
    assign illegal_o   = ill_q;
    assign op_count_o  = cnt_q;

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Bench for alu_exec_pipe: directed vectors, a queue-based reference model and
// a per-cycle compare process on the falling edge.
module tb_alu_exec_pipe;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] src_a_i = '0;
    logic [31:0] src_b_i = '0;
    logic [2:0]  alu_control_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] result_o;
    logic        zero_o, overflow_o, illegal_o;
    logic [31:0] op_count_o;

    alu_exec_pipe #(.WIDTH(32), .CNT_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .src_a_i(src_a_i), .src_b_i(src_b_i), .alu_control_i(alu_control_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .result_o(result_o), .zero_o(zero_o), .overflow_o(overflow_o),
        .illegal_o(illegal_o), .op_count_o(op_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        ov;
        logic        ill;
    } exp_t;

    typedef struct packed {
        exp_t e;
        int   stamp;
    } ent_t;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_n   = 0;
    ent_t        q[$];
    logic [31:0] drained[$];
    logic [31:0] model_cnt = '0;
    logic        rst_pending = 1'b1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, got, exp);
    endtask

    // Reference: signed arithmetic in 64 bits, overflow as range escape
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        longint sa, sb, r;
        exp_t   e;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 0;
        e  = '0;
        case (c)
            3'd0: begin r = sa + sb; e.res = r[31:0]; e.ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            3'd1: begin r = sa - sb; e.res = r[31:0]; e.ov = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
            3'd2: e.res = a & b;
            3'd3: e.res = a | b;
            3'd5: e.res = (sa < sb) ? 32'd1 : 32'd0;
            default: e.ill = 1'b1;
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    always @(posedge clk_i) edge_n++;

    // Compare outputs against the model, then record the transfers the next edge will take
    always @(negedge clk_i) begin
        logic exp_valid;
        if (rst_pending) begin
            chk("rst_out_valid", 64'(out_valid_o), 64'd0);
            chk("rst_result", 64'(result_o), 64'd0);
            chk("rst_flags", 64'({zero_o, overflow_o, illegal_o}), 64'd0);
            chk("rst_op_count", 64'(op_count_o), 64'd0);
        end else begin
            exp_valid = (q.size() > 0) && (edge_n >= q[0].stamp + 1);
            chk("out_valid", 64'(out_valid_o), 64'(exp_valid));
            chk("in_ready", 64'(in_ready_o), 64'((q.size() < 2) || out_ready_i));
            chk("op_count", 64'(op_count_o), 64'(model_cnt));
            if (out_valid_o && q.size() > 0) begin
                chk("result", 64'(result_o), 64'(q[0].e.res));
                chk("flags", 64'({zero_o, overflow_o, illegal_o}),
                    64'({q[0].e.z, q[0].e.ov, q[0].e.ill}));
            end
        end
        rst_pending = !rst_ni;
        if (!rst_ni) begin
            q.delete();
            model_cnt = '0;
        end else begin
            if (out_valid_o && out_ready_i) begin
                if (q.size() > 0) void'(q.pop_front());
                drained.push_back(result_o);
                model_cnt = model_cnt + 32'd1;
            end
            if (in_valid_i && in_ready_o)
                q.push_back('{e: model(src_a_i, src_b_i, alu_control_i), stamp: edge_n + 1});
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        logic acc;
        int   n;
        in_valid_i    = 1'b1;
        src_a_i       = a;
        src_b_i       = b;
        alu_control_i = c;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            @(negedge clk_i);
            acc = in_ready_o;
            step();
            n++;
        end
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
        in_valid_i = 1'b0;
    endtask

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  c;
        exp_t        e;
    } vec_t;

    vec_t vecs[8];
    int   base;

    initial begin
        vecs[0] = '{32'h7FFF_FFFF, 32'd1,         3'd0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0}};
        vecs[1] = '{32'd5,         32'd5,         3'd1, '{32'd0,         1'b1, 1'b0, 1'b0}};
        vecs[2] = '{32'hFFFF_FFFF, 32'd1,         3'd5, '{32'd1,         1'b0, 1'b0, 1'b0}};
        vecs[3] = '{32'd1,         32'hFFFF_FFFF, 3'd5, '{32'd0,         1'b1, 1'b0, 1'b0}};
        vecs[4] = '{32'd3,         32'd4,         3'd6, '{32'd0,         1'b1, 1'b0, 1'b1}};
        vecs[5] = '{32'h8000_0000, 32'd1,         3'd1, '{32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0}};
        vecs[6] = '{32'hF0F0_00FF, 32'h0FF0_0F0F, 3'd2, '{32'h00F0_000F, 1'b0, 1'b0, 1'b0}};
        vecs[7] = '{32'hF000_0001, 32'h0000_0F00, 3'd3, '{32'hF000_0F01, 1'b0, 1'b0, 1'b0}};

        // Pin the model against hand-computed values
        for (int i = 0; i < 8; i++)
            chk($sformatf("model_vec%0d", i), 64'(model(vecs[i].a, vecs[i].b, vecs[i].c)), 64'(vecs[i].e));

        // Reset held over three edges with a valid bundle presented
        rst_ni = 1'b0; in_valid_i = 1'b1; src_a_i = 32'd9; src_b_i = 32'd9;
        repeat (3) step();
        rst_ni = 1'b1; in_valid_i = 1'b0;
        @(negedge clk_i);
        chk("post_rst_in_ready", 64'(in_ready_o), 64'd1);
        chk("post_rst_valid", 64'(out_valid_o), 64'd0);
        step();

        // Directed vectors with the sink always ready
        out_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) send(vecs[i].a, vecs[i].b, vecs[i].c);
        repeat (4) step();
        chk("directed_count", 64'(op_count_o), 64'd8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("drained_vec%0d", i), 64'(drained[i]), 64'(vecs[i].e.res));

        // Backpressured stream of four adds
        base = drained.size();
        out_ready_i = 1'b0;
        fork
            begin
                repeat (4) @(posedge clk_i);
                #1 out_ready_i = 1'b1;
            end
            begin
                send(32'd1, 32'd1, 3'd0);
                send(32'd2, 32'd2, 3'd0);
                @(negedge clk_i);
                chk("bp_in_ready_low", 64'(in_ready_o), 64'd0);
                step();
                send(32'd3, 32'd3, 3'd0);
                send(32'd4, 32'd4, 3'd0);
            end
        join
        repeat (4) step();
        chk("bp_drained", 64'(drained.size() - base), 64'd4);
        for (int i = 0; i < 4; i++)
            if (base + i < drained.size())
                chk($sformatf("bp_res%0d", i), 64'(drained[base + i]), 64'(2 * (i + 1)));
        chk("bp_count", 64'(op_count_o), 64'd12);

        // Reset with two bundles in flight
        out_ready_i = 1'b0;
        send(32'd10, 32'd20, 3'd0);
        send(32'd30, 32'd40, 3'd0);
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        base = drained.size();
        out_ready_i = 1'b1;
        repeat (5) step();
        chk("midrst_no_output", 64'(drained.size() - base), 64'd0);
        chk("midrst_count", 64'(op_count_o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_exec_pipe.md
Name: alu_exec_pipe

Overview:
- Execute-side consumer of the 3-bit ALU control code produced by the ALU control decoder.
- Accepts operand pairs plus the control code on a valid/ready handshake.
- Computes the result in a 2-stage pipeline (operand register, then result register) and presents result and flags on a valid/ready output handshake with full backpressure.
- Sits between the register-read/operand-mux logic and the writeback/branch-resolve logic.

Parameters:
- WIDTH, 32, datapath width of operands and result (must be >= 2).
- CNT_WIDTH, 32, width of the completed-operation counter.

Ports:
- clk_i  input  1  clock, all state updates on rising edge.
- rst_ni  input  1  reset is synchronous and active-low.
- in_valid_i  input  1  operand/control bundle valid.
- in_ready_o  output  1  pipe can accept bundle this cycle.
- src_a_i  input  WIDTH  operand A.
- src_b_i  input  WIDTH  operand B.
- alu_control_i  input  3  000 add, 001 sub, 010 and, 011 or, 101 slt; 100/110/111 illegal.
- out_valid_o  output  1  result bundle valid.
- out_ready_i  input  1  downstream accepts result.
- result_o  output  WIDTH  ALU result.
- zero_o  output  1  result_o == 0.
- overflow_o  output  1  signed overflow (add/sub only).
- illegal_o  output  1  control code was illegal.
- op_count_o  output  CNT_WIDTH  number of result handshakes completed.

Behaviour:
- Reset (rst_ni low at a rising edge):
  - s1_valid=0, s2_valid=0, out_valid_o=0.
  - result_o=0, zero_o=0, overflow_o=0, illegal_o=0, op_count_o=0.
  - Reset overrides all handshakes in that cycle. In-flight operations are discarded; no result is emitted for them.
- Handshakes:
  - Input transfer when in_valid_i & in_ready_o.
  - Output transfer when out_valid_o & out_ready_i.
- Ready chain (combinational):
  - s2_ready = !s2_valid | out_ready_i.
  - s1_ready = !s1_valid | s2_ready.
  - in_ready_o = s1_ready.
  - in_ready_o never depends on in_valid_i.
- Stage 1: on input transfer, latch src_a, src_b and alu_control; set s1_valid. If s1 advances with no new input, clear s1_valid.
- Stage 2: when s1_valid & s2_ready, compute from s1 contents and load the result registers; set s2_valid. If s2 drains (output transfer) with nothing advancing, clear s2_valid.
- out_valid_o = s2_valid. Outputs are registered and held stable while out_valid_o & !out_ready_i.
- Latency and throughput:
  - 2 cycles: a bundle accepted at edge N appears with out_valid_o=1 after edge N+1.
  - Throughput 1 per cycle with out_ready_i held high.
  - No bubbles inserted, no bundles dropped or duplicated under any valid/ready pattern.
- Arithmetic (all mod 2^WIDTH):
  - add: a+b. sub: a-b. and: a&b. or: a|b.
  - slt: {WIDTH-1 zeros, signed(a)<signed(b)}.
- overflow_o:
  - add: operand signs equal and result sign differs.
  - sub: operand signs differ and result sign differs from a.
  - 0 for all other codes.
- Illegal codes: result_o=0, illegal_o=1, overflow_o=0, zero_o=1.
- zero_o is computed from the registered result value for every code.
- op_count_o increments by 1 on each output transfer and wraps from all-ones to 0.
- Simultaneous events:
  - Input accept, s1→s2 advance and output drain in the same cycle are all legal: pipeline full, out_ready_i=1, in_valid_i=1 → steady streaming.
  - With the pipeline full and out_ready_i=0, in_ready_o=0.

Test Plan:
- Reset with rst_ni=0 over 3 edges while in_valid_i=1 → out_valid_o=0, op_count_o=0, in_ready_o=1 after release; no spurious output.
- Add a=0x7FFFFFFF, b=1, out_ready_i=1 → 2 cycles later result_o=0x80000000, overflow_o=1, zero_o=0, op_count_o becomes 1 after the transfer.
- Sub a=5, b=5 → result_o=0, zero_o=1, overflow_o=0.
- slt a=0xFFFFFFFF (-1), b=1 → result 1.
- slt a=1, b=0xFFFFFFFF → result 0.
- Illegal code 110 with a=3, b=4 → result_o=0, illegal_o=1, zero_o=1.
- Backpressure stream: send 4 bundles back-to-back (add 1+1, 2+2, 3+3, 4+4) with out_ready_i=0 for 4 cycles, then 1.
  - in_ready_o drops to 0 after 2 accepts.
  - Outputs are held stable while stalled.
  - Results 2, 4, 6, 8 appear in order with no loss or duplication; op_count_o=4.
- Reset mid-operation: two bundles in flight, assert rst_ni=0 for 1 edge → out_valid_o=0, op_count_o=0, and no in-flight result ever appears.
